apb_master_controller: RTL and testbench

//  APB initiator: converts a simple valid/ready request stream (from the AHB slave side of the

---
 rtl/apb_master_controller_if.sv | 42 ++++
 rtl/apb_master_controller.sv | 95 +++++++++
 tb/tb_apb_master_controller.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/apb_master_controller_if.sv
// Bundled request/response and APB signals of the APB master controller.
// The Pready signal exists only when APB_PREADY_EN is defined.
interface apb_master_controller_if #(
  parameter int NSEL = 3
);
  logic            Hvalid;
  logic            Hwrite;
  logic [31:0]     Haddr;
  logic [31:0]     Hwdata;
  logic            Hreadyout;
  logic [31:0]     Hrdata;
  logic            Rvalid;
  logic            Hresp;
  logic [NSEL-1:0] Pselx;
  logic            Penable;
  logic            Pwrite;
  logic [31:0]     Paddr;
  logic [31:0]     Pwdata;
  logic [31:0]     Prdata;
`ifdef APB_PREADY_EN
  logic            Pready;
`endif

  // The controller side drives the response and the APB request signals.
  modport master (
`ifdef APB_PREADY_EN
    input  Pready,
`endif
    input  Hvalid, Hwrite, Haddr, Hwdata, Prdata,
    output Hreadyout, Hrdata, Rvalid, Hresp,
    output Pselx, Penable, Pwrite, Paddr, Pwdata
  );

  modport slave (
`ifdef APB_PREADY_EN
    output Pready,
`endif
    output Hvalid, Hwrite, Haddr, Hwdata, Prdata,
    input  Hreadyout, Hrdata, Rvalid, Hresp,
    input  Pselx, Penable, Pwrite, Paddr, Pwdata
  );
endinterface

// File: rtl/apb_master_controller.sv
// APB initiator turning a valid/ready request stream into APB SETUP/ACCESS cycles.
// Optional wait-state support (Pready input) is enabled by defining APB_PREADY_EN.
module apb_master_controller #(
  parameter int          NSEL        = 3,
  parameter logic [31:0] BASE_ADDR   = 32'h8000_0000,
  parameter int          REGION_LOG2 = 26
) (
  input logic                    Hclk,
  input logic                    Hresetn,
  apb_master_controller_if.master bus
);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, ERR} state_t;

  state_t          state;
  state_t          state_nxt;
  logic            pready;
  logic            complete;
  logic            ready;
  logic            accept;
  logic            hit;
  logic [31:0]     offset;
  logic [31:0]     idx;
  logic [NSEL-1:0] sel_dec;

`ifdef APB_PREADY_EN
  assign pready = bus.Pready;
`else
  assign pready = 1'b1;
`endif

  // Addresses below the window are a miss; the compare stops the subtraction from wrapping into a hit.
  always_comb begin
    offset = bus.Haddr - BASE_ADDR;
    idx    = offset >> REGION_LOG2;
    hit    = (bus.Haddr >= BASE_ADDR) && (idx < 32'(NSEL));
    for (int i = 0; i < NSEL; i++) begin
      sel_dec[i] = (idx == 32'(i));
    end
  end

  always_ff @(posedge Hclk or negedge Hresetn) begin
    if (!Hresetn) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    complete  = 1'b0;
    ready     = 1'b0;
    case (state)
      IDLE:    ready = 1'b1;
      ACCESS: begin
        complete = pready;
        ready    = pready;
      end
      default: ready = 1'b0;
    endcase
    accept = bus.Hvalid & ready;
    // A completing ACCESS behaves like IDLE so back-to-back transfers skip the idle cycle.
    if (ready)                state_nxt = accept ? (hit ? SETUP : ERR) : IDLE;
    else if (state == SETUP)  state_nxt = ACCESS;
    else if (state == ERR)    state_nxt = IDLE;
  end

  assign bus.Hreadyout = ready;

  always_ff @(posedge Hclk or negedge Hresetn) begin
    if (!Hresetn) begin
      bus.Pselx   <= '0;
      bus.Penable <= 1'b0;
      bus.Pwrite  <= 1'b0;
      bus.Paddr   <= '0;
      bus.Pwdata  <= '0;
      bus.Hrdata  <= '0;
      bus.Rvalid  <= 1'b0;
      bus.Hresp   <= 1'b0;
    end else begin
      bus.Rvalid  <= complete & ~bus.Pwrite;
      bus.Hresp   <= accept & ~hit;
      bus.Penable <= (state_nxt == ACCESS);
      if (complete && !bus.Pwrite) bus.Hrdata <= bus.Prdata;
      // The P* request registers double as the latched request, so a miss leaves them untouched.
      if (accept && hit) begin
        bus.Pselx  <= sel_dec;
        bus.Paddr  <= bus.Haddr;
        bus.Pwrite <= bus.Hwrite;
        bus.Pwdata <= bus.Hwdata;
      end else if (complete) begin
        bus.Pselx  <= '0;
      end
    end
  end

endmodule

// File: tb/tb_apb_master_controller.sv
// Self-checking bench for apb_master_controller: directed cases plus randomized traffic
// checked every cycle against a cycle-timeline reference model.
module tb_apb_master_controller;

  localparam int          NSEL   = 3;
  localparam logic [31:0] BASE   = 32'h8000_0000;
  localparam int unsigned REGION = 32'h0400_0000;
  localparam int          NCYC   = 2048;

  logic Hclk = 1'b0;
  logic Hresetn = 1'b0;

  apb_master_controller_if #(.NSEL(NSEL)) bus ();

  apb_master_controller #(.NSEL(NSEL), .BASE_ADDR(BASE), .REGION_LOG2(26)) dut (
    .Hclk    (Hclk),
    .Hresetn (Hresetn),
    .bus     (bus.master)
  );

  always #5 Hclk = ~Hclk;

`ifdef APB_PREADY_EN
  initial bus.Pready = 1'b1;
`endif

  int vectors = 0;
  int miscompares = 0;
  int k = 0;

  // Timeline model: what each future cycle must look like (0 idle, 1 setup, 2 access, 3 error).
  int          kind  [NCYC];
  int          sIdx  [NCYC];
  logic [31:0] sAddr [NCYC];
  logic [31:0] sData [NCYC];
  bit          sWrite[NCYC];
  bit          rv    [NCYC];
  logic [31:0] rdata [NCYC];
  logic [31:0] rdHold = '0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s at cycle %0d: got %h, want %h", name, k, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic w, input logic [31:0] a,
                               input logic [31:0] d, input logic [31:0] p);
    @(posedge Hclk);
    #1;
    bus.Hvalid = v;
    bus.Hwrite = w;
    bus.Haddr  = a;
    bus.Hwdata = d;
    bus.Prdata = p;
  endtask

  function automatic bit modelHit(input logic [31:0] a);
    int unsigned off;
    off = a - BASE;
    return (a >= BASE) && ((off / REGION) < NSEL);
  endfunction

  // Compare process: checks every cycle and advances the model from the sampled inputs.
  initial begin
    for (int i = 0; i < NCYC; i++) begin
      kind[i] = 0;
      rv[i]   = 0;
    end
    forever begin
      @(negedge Hclk);
      if (k + 4 < NCYC) begin
        if (!Hresetn) begin
          checkOutput("rst_pselx",   32'(bus.Pselx), 0);
          checkOutput("rst_penable", 32'(bus.Penable), 0);
          checkOutput("rst_pwrite",  32'(bus.Pwrite), 0);
          checkOutput("rst_paddr",   bus.Paddr, 0);
          checkOutput("rst_pwdata",  bus.Pwdata, 0);
          checkOutput("rst_hrdata",  bus.Hrdata, 0);
          checkOutput("rst_rvalid",  32'(bus.Rvalid), 0);
          checkOutput("rst_hresp",   32'(bus.Hresp), 0);
          checkOutput("rst_ready",   32'(bus.Hreadyout), 1);
          rdHold = '0;
          for (int j = k; j < k + 4; j++) begin
            kind[j] = 0;
            rv[j]   = 0;
          end
        end else begin
          automatic bit expReady = (kind[k] != 1) && (kind[k] != 3);
          automatic bit active   = (kind[k] == 1) || (kind[k] == 2);
          if (rv[k]) rdHold = rdata[k];
          checkOutput("hreadyout", 32'(bus.Hreadyout), 32'(expReady));
          checkOutput("pselx",     32'(bus.Pselx), active ? (32'd1 << sIdx[k]) : 32'd0);
          checkOutput("penable",   32'(bus.Penable), 32'(kind[k] == 2));
          checkOutput("hresp",     32'(bus.Hresp), 32'(kind[k] == 3));
          checkOutput("rvalid",    32'(bus.Rvalid), 32'(rv[k]));
          checkOutput("hrdata",    bus.Hrdata, rdHold);
          if (active) begin
            checkOutput("paddr",  bus.Paddr, sAddr[k]);
            checkOutput("pwrite", 32'(bus.Pwrite), 32'(sWrite[k]));
            checkOutput("pwdata", bus.Pwdata, sData[k]);
          end
          if (kind[k] == 2 && !sWrite[k]) begin
            rv[k+1]    = 1;
            rdata[k+1] = bus.Prdata;
          end
          if (bus.Hvalid && expReady) begin
            if (modelHit(bus.Haddr)) begin
              for (int j = k + 1; j <= k + 2; j++) begin
                kind[j]   = j - k;
                sIdx[j]   = int'((bus.Haddr - BASE) / REGION);
                sAddr[j]  = bus.Haddr;
                sData[j]  = bus.Hwdata;
                sWrite[j] = bus.Hwrite;
              end
            end else begin
              kind[k+1] = 3;
            end
          end
        end
      end
      k++;
    end
  end

  function automatic logic [31:0] randAddr();
    case ($urandom_range(0, 3))
      0:       return (BASE + 32'($urandom_range(0, 32'h0BFF_FFFF))) & ~32'h3;
      1:       return 32'h8BFF_FFF0 + 32'($urandom_range(0, 31));
      2:       return 32'h7FFF_FFF0 + 32'($urandom_range(0, 31));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    bit found;
    bus.Hvalid = 0;
    bus.Hwrite = 0;
    bus.Haddr  = '0;
    bus.Hwdata = '0;
    bus.Prdata = '0;
    repeat (3) @(posedge Hclk);
    #1 Hresetn = 1'b1;
    applyStimulus(0, 0, 0, 0, 0);

    // Single write into slave 0
    applyStimulus(1, 1, 32'h8000_0010, 32'hDEAD_BEEF, 0);
    applyStimulus(0, 0, 0, 0, 0);
    checkOutput("t1_setup_sel", 32'(bus.Pselx), 32'b001);
    checkOutput("t1_setup_en",  32'(bus.Penable), 0);
    applyStimulus(0, 0, 0, 0, 0);
    checkOutput("t1_acc_en",    32'(bus.Penable), 1);
    checkOutput("t1_acc_wr",    32'(bus.Pwrite), 1);
    checkOutput("t1_acc_addr",  bus.Paddr, 32'h8000_0010);
    checkOutput("t1_acc_data",  bus.Pwdata, 32'hDEAD_BEEF);
    applyStimulus(0, 0, 0, 0, 0);
    checkOutput("t1_no_rvalid", 32'(bus.Rvalid), 0);

    // Read from slave 1
    applyStimulus(1, 0, 32'h8400_0004, 0, 32'hA5);
    applyStimulus(0, 0, 0, 0, 32'hA5);
    checkOutput("t2_sel", 32'(bus.Pselx), 32'b010);
    applyStimulus(0, 0, 0, 0, 32'hA5);
    checkOutput("t2_wr", 32'(bus.Pwrite), 0);
    applyStimulus(0, 0, 0, 0, 0);
    checkOutput("t2_rvalid", 32'(bus.Rvalid), 1);
    checkOutput("t2_hrdata", bus.Hrdata, 32'hA5);

    // Back-to-back writes with Hvalid held
    applyStimulus(1, 1, 32'h8800_0000, 32'h1111, 0);
    applyStimulus(1, 1, 32'h8000_0000, 32'h2222, 0);
    checkOutput("t3_sel_a",    32'(bus.Pselx), 32'b100);
    checkOutput("t3_busy",     32'(bus.Hreadyout), 0);
    applyStimulus(1, 1, 32'h8000_0000, 32'h2222, 0);
    checkOutput("t3_complete", 32'(bus.Hreadyout), 1);
    applyStimulus(0, 0, 0, 0, 0);
    checkOutput("t3_sel_b",    32'(bus.Pselx), 32'b001);
    checkOutput("t3_setup_en", 32'(bus.Penable), 0);
    applyStimulus(0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0);

    // Misses below and above the window
    applyStimulus(1, 0, 32'h7FFF_FFFC, 0, 0);
    applyStimulus(0, 0, 0, 0, 0);
    checkOutput("t4_lo_resp",  32'(bus.Hresp), 1);
    checkOutput("t4_lo_ready", 32'(bus.Hreadyout), 0);
    checkOutput("t4_lo_sel",   32'(bus.Pselx), 0);
    applyStimulus(1, 0, 32'h8C00_0000, 0, 0);
    applyStimulus(0, 0, 0, 0, 0);
    checkOutput("t4_hi_resp",  32'(bus.Hresp), 1);
    checkOutput("t4_hi_sel",   32'(bus.Pselx), 0);
    applyStimulus(0, 0, 0, 0, 0);
    checkOutput("t4_resp_end", 32'(bus.Hresp), 0);

    // Randomized traffic
    for (int n = 0; n < 500; n++) begin
      applyStimulus($urandom_range(0, 99) < 70, $urandom_range(0, 1), randAddr(), $urandom, $urandom);
    end

    // Reset in the middle of an ACCESS cycle
    applyStimulus(1, 0, 32'h8000_0000, 0, 0);
    found = 0;
    for (int n = 0; n < 20 && !found; n++) begin
      @(posedge Hclk);
      #1;
      if (bus.Penable) begin
        Hresetn    = 1'b0;
        bus.Hvalid = 0;
        found      = 1;
      end
    end
    checkOutput("t5_access_seen", 32'(found), 1);
    #1;
    checkOutput("t5_sel",   32'(bus.Pselx), 0);
    checkOutput("t5_en",    32'(bus.Penable), 0);
    checkOutput("t5_ready", 32'(bus.Hreadyout), 1);
    @(posedge Hclk);
    #1 Hresetn = 1'b1;
    applyStimulus(0, 0, 0, 0, 0);
    applyStimulus(1, 0, 32'h8000_0000, 0, 32'h1234);
    applyStimulus(0, 0, 0, 0, 32'h1234);
    applyStimulus(0, 0, 0, 0, 32'h1234);
    applyStimulus(0, 0, 0, 0, 0);
    checkOutput("t5_rvalid", 32'(bus.Rvalid), 1);
    checkOutput("t5_hrdata", bus.Hrdata, 32'h1234);

    repeat (3) applyStimulus(0, 0, 0, 0, 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
